// File: rtl/axi_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_mem_slave
// Description : AXI3-style memory slave. The write and read channels are
//               independent FSMs, and each accepts one burst at a time.
//               Bursts can be FIXED or INCR. WRAP bursts work only when the
//               macro AXI_MEM_SLAVE_WRAP_EN is defined; otherwise they are
//               treated as reserved. Memory is byte-maskable and is not
//               cleared on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_mem_slave #(
   parameter int DATA_W    = 32,
   parameter int ID_W      = 4,
   parameter int MEM_DEPTH = 256
) (
   input  logic                clk,
   input  logic                rstn,
   // write address
   input  logic                awvalid,
   output logic                awready,
   input  logic [ID_W-1:0]     awid,
   input  logic [31:0]         awaddr,
   input  logic [3:0]          awlen,
   input  logic [2:0]          awsize,
   input  logic [1:0]          awburst,
   // write data
   input  logic                wvalid,
   output logic                wready,
   input  logic [ID_W-1:0]     wid,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic                wlast,
   // write response
   output logic                bvalid,
   input  logic                bready,
   output logic [ID_W-1:0]     bid,
   output logic [1:0]          bresp,
   // read address
   input  logic                arvalid,
   output logic                arready,
   input  logic [ID_W-1:0]     arid,
   input  logic [31:0]         araddr,
   input  logic [3:0]          arlen,
   input  logic [2:0]          arsize,
   input  logic [1:0]          arburst,
   // read data
   output logic                rvalid,
   input  logic                rready,
   output logic [ID_W-1:0]     rid,
   output logic [DATA_W-1:0]   rdata,
   output logic [DATA_W/8-1:0] rstrb,
   output logic [1:0]          rresp,
   output logic                rlast
);

   localparam int          c_BYTES     = DATA_W / 8;
   localparam int          c_BSHIFT    = $clog2(c_BYTES);
   localparam int          c_IDX_W     = $clog2(MEM_DEPTH);
   localparam logic [2:0]  c_SIZE_FULL = 3'(c_BSHIFT);
   localparam logic [31:0] c_LIMIT     = 32'(MEM_DEPTH * c_BYTES);
   localparam logic [1:0]  c_OKAY      = 2'b00;
   localparam logic [1:0]  c_SLVERR    = 2'b10;
   localparam logic [1:0]  c_DECERR    = 2'b11;
`ifdef AXI_MEM_SLAVE_WRAP_EN
   localparam logic        c_WRAP_EN   = 1'b1;
`else
   localparam logic        c_WRAP_EN   = 1'b0;
`endif

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} t_wstate;
   typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} t_rstate;

   // Next beat address. FIXED and reserved bursts hold the address. WRAP
   // stays inside the aligned (len+1)*2^size window.
   function automatic logic [31:0] f_next(input logic [31:0] a, input logic [2:0] s,
                                          input logic [3:0] l, input logic [1:0] b);
      logic [31:0] inc, win, mask;
      inc  = 32'd1 << s;
      win  = ({28'd0, l} + 32'd1) << s;
      mask = win - 32'd1;
      case (b)
         2'b01:   return a + inc;
         2'b10:   return (a & ~mask) | ((a + inc) & mask);
         default: return a;
      endcase
   endfunction

   // A burst-level error suppresses every beat of the burst: a reserved
   // burst, a narrow size, or (WRAP) a disabled wrap or an illegal length.
   function automatic logic f_bad(input logic [1:0] b, input logic [2:0] s, input logic [3:0] l);
      logic bad, len_ok;
      len_ok = (l == 4'd1) || (l == 4'd3) || (l == 4'd7) || (l == 4'd15);
      bad    = (s != c_SIZE_FULL);
      case (b)
         2'b10:   bad = bad | ~c_WRAP_EN | ~len_ok;
         2'b11:   bad = 1'b1;
         default: ;
      endcase
      return bad;
   endfunction

   function automatic logic [1:0] f_max(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

   logic [DATA_W-1:0] r_mem [MEM_DEPTH];

   // ---------------- write path ----------------
   t_wstate          r_wstate;
   logic [ID_W-1:0]  r_aw_id;
   logic [31:0]      r_w_addr;
   logic [3:0]       r_aw_len;
   logic [2:0]       r_aw_size;
   logic [1:0]       r_aw_burst;
   logic [3:0]       r_w_cnt;
   logic [1:0]       r_w_err;
   logic             r_w_bad;
   logic             r_w_over;

   logic              w_w_fire;
   logic              w_wlast_bad;
   logic [1:0]        w_wbeat_err;
   logic              w_mem_we;
   logic [c_IDX_W-1:0] w_w_idx;

   // Classify the current write beat. DECERR takes priority over SLVERR.
   always_comb begin
      w_w_fire    = (r_wstate == W_DATA) && wvalid && wready;
      w_wlast_bad = (wlast != (r_w_cnt == r_aw_len)) || r_w_over;
      w_w_idx     = r_w_addr[c_BSHIFT +: c_IDX_W];
      if (r_w_addr >= c_LIMIT)
         w_wbeat_err = c_DECERR;
      else if (r_w_bad || (wid != r_aw_id) || w_wlast_bad)
         w_wbeat_err = c_SLVERR;
      else
         w_wbeat_err = c_OKAY;
      w_mem_we = w_w_fire && (w_wbeat_err == c_OKAY) && !rstn;
   end

   // Byte-masked memory write. This block is not reset, so contents survive reset.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int b = 0; b < c_BYTES; b++) begin
            if (wstrb[b]) r_mem[w_w_idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   // Write FSM: accept AW, consume beats until wlast, then hold B until accepted.
   always_ff @(posedge clk) begin
      if (rstn) begin
         r_wstate   <= W_IDLE;
         awready    <= 1'b1;
         wready     <= 1'b0;
         bvalid     <= 1'b0;
         bid        <= '0;
         bresp      <= c_OKAY;
         r_w_cnt    <= 4'd0;
         r_w_err    <= c_OKAY;
         r_w_bad    <= 1'b0;
         r_w_over   <= 1'b0;
      end else begin
         case (r_wstate)
            W_IDLE: begin
               if (awvalid && awready) begin
                  r_aw_id    <= awid;
                  r_w_addr   <= awaddr;
                  r_aw_len   <= awlen;
                  r_aw_size  <= awsize;
                  r_aw_burst <= awburst;
                  r_w_bad    <= f_bad(awburst, awsize, awlen);
                  r_w_cnt    <= 4'd0;
                  r_w_err    <= c_OKAY;
                  r_w_over   <= 1'b0;
                  awready    <= 1'b0;
                  wready     <= 1'b1;
                  r_wstate   <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_w_fire) begin
                  r_w_err  <= f_max(r_w_err, w_wbeat_err);
                  r_w_addr <= f_next(r_w_addr, r_aw_size, r_aw_len, r_aw_burst);
                  r_w_cnt  <= r_w_cnt + 4'd1;
                  if ((r_w_cnt == r_aw_len) && !wlast) r_w_over <= 1'b1;
                  if (wlast) begin
                     wready   <= 1'b0;
                     bvalid   <= 1'b1;
                     bid      <= r_aw_id;
                     bresp    <= f_max(r_w_err, w_wbeat_err);
                     r_wstate <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (bready) begin
                  bvalid   <= 1'b0;
                  awready  <= 1'b1;
                  r_wstate <= W_IDLE;
               end
            end
            default: begin
               r_wstate <= W_IDLE;
               awready  <= 1'b1;
               wready   <= 1'b0;
               bvalid   <= 1'b0;
            end
         endcase
      end
   end

   // ---------------- read path ----------------
   t_rstate          r_rstate;
   logic [31:0]      r_ar_addr;
   logic [3:0]       r_ar_len;
   logic [2:0]       r_ar_size;
   logic [1:0]       r_ar_burst;
   logic [3:0]       r_r_cnt;
   logic             r_r_bad;

   logic [31:0]        w_rd_addr;
   logic               w_rd_bad;
   logic [1:0]         w_rd_resp;
   logic [c_IDX_W-1:0] w_rd_idx;
   logic [DATA_W-1:0]  w_rd_data;

   // Data and response for the next beat to present. The first beat comes
   // from the AR inputs; later beats come from the advanced address register.
   always_comb begin
      w_rd_addr = (r_rstate == R_IDLE) ? araddr : r_ar_addr;
      w_rd_bad  = (r_rstate == R_IDLE) ? f_bad(arburst, arsize, arlen) : r_r_bad;
      w_rd_idx  = w_rd_addr[c_BSHIFT +: c_IDX_W];
      if (w_rd_addr >= c_LIMIT)
         w_rd_resp = c_DECERR;
      else if (w_rd_bad)
         w_rd_resp = c_SLVERR;
      else
         w_rd_resp = c_OKAY;
      w_rd_data = (w_rd_resp == c_OKAY) ? r_mem[w_rd_idx] : '0;
   end

   assign rstrb = '1;

   // Read FSM. Beat registers load on the AR handshake and on every R
   // handshake except the last, and hold while the master stalls.
   always_ff @(posedge clk) begin
      if (rstn) begin
         r_rstate <= R_IDLE;
         arready  <= 1'b1;
         rvalid   <= 1'b0;
         rlast    <= 1'b0;
         rid      <= '0;
         rresp    <= c_OKAY;
         rdata    <= '0;
         r_r_cnt  <= 4'd0;
         r_r_bad  <= 1'b0;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               if (arvalid && arready) begin
                  r_ar_len   <= arlen;
                  r_ar_size  <= arsize;
                  r_ar_burst <= arburst;
                  r_r_bad    <= w_rd_bad;
                  r_ar_addr  <= f_next(araddr, arsize, arlen, arburst);
                  r_r_cnt    <= 4'd0;
                  rid        <= arid;
                  rdata      <= w_rd_data;
                  rresp      <= w_rd_resp;
                  rlast      <= (arlen == 4'd0);
                  rvalid     <= 1'b1;
                  arready    <= 1'b0;
                  r_rstate   <= R_DATA;
               end
            end
            R_DATA: begin
               if (rvalid && rready) begin
                  if (rlast) begin
                     rvalid   <= 1'b0;
                     rlast    <= 1'b0;
                     arready  <= 1'b1;
                     r_rstate <= R_IDLE;
                  end else begin
                     rdata     <= w_rd_data;
                     rresp     <= w_rd_resp;
                     rlast     <= ((r_r_cnt + 4'd1) == r_ar_len);
                     r_r_cnt   <= r_r_cnt + 4'd1;
                     r_ar_addr <= f_next(r_ar_addr, r_ar_size, r_ar_len, r_ar_burst);
                  end
               end
            end
            default: begin
               r_rstate <= R_IDLE;
               arready  <= 1'b1;
               rvalid   <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_mem_slave
// Description : Directed, self-checking bench for axi_mem_slave. It drives a
//               table of single-beat vectors, then hand-written burst, stall,
//               wrap, error and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_mem_slave;
   localparam int DATA_W = 32, ID_W = 4, MEM_DEPTH = 256;

   logic clk = 1'b0, rstn = 1'b1;
   logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic arvalid, arready, rvalid, rready, rlast;
   logic [3:0]  awid, wid, bid, arid, rid, awlen, arlen, wstrb, rstrb;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;

   always #5 clk = ~clk;

   axi_mem_slave #(.DATA_W(DATA_W), .ID_W(ID_W), .MEM_DEPTH(MEM_DEPTH)) dut (
      .clk(clk), .rstn(rstn),
      .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
      .awsize(awsize), .awburst(awburst),
      .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
      .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rstrb(rstrb),
      .rresp(rresp), .rlast(rlast)
   );

   int n_cmp = 0, n_bad = 0;
   logic [31:0] wd [16];
   logic [3:0]  ws [16];
   logic [31:0] rd_d [16];
   logic [1:0]  rd_r [16];
   logic        rd_l [16];
   logic [3:0]  rd_id;
   int          rd_n;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tmo(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out waiting for handshake", nm);
   endtask

   task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                            input int last_at, input logic [3:0] wid_x,
                            output logic [1:0] resp, output logic [3:0] bid_o);
      bit ok;
      @(negedge clk);
      awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
      ok = 0;
      for (int g = 0; g < 50; g++) begin
         if (awready) begin ok = 1; break; end
         @(negedge clk);
      end
      if (!ok) tmo("aw_handshake");
      @(posedge clk); @(negedge clk);
      awvalid = 1'b0;
      for (int i = 0; i < nbeats; i++) begin
         wvalid = 1'b1; wid = id ^ wid_x; wdata = wd[i]; wstrb = ws[i]; wlast = (i == last_at);
         ok = 0;
         for (int g = 0; g < 50; g++) begin
            if (wready) begin ok = 1; break; end
            @(negedge clk);
         end
         if (!ok) tmo("w_handshake");
         @(posedge clk); @(negedge clk);
      end
      wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
      ok = 0;
      for (int g = 0; g < 50; g++) begin
         if (bvalid) begin ok = 1; break; end
         @(negedge clk);
      end
      if (!ok) tmo("b_handshake");
      resp = bresp; bid_o = bid;
      @(posedge clk); @(negedge clk);
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int stall_beat);
      bit ok, stalled, done;
      logic [31:0] sd; logic sl; logic [1:0] sr;
      stalled = 0; done = 0; rd_n = 0;
      @(negedge clk);
      arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
      rready = 1'b1;
      ok = 0;
      for (int g = 0; g < 50; g++) begin
         if (arready) begin ok = 1; break; end
         @(negedge clk);
      end
      if (!ok) tmo("ar_handshake");
      @(posedge clk); @(negedge clk);
      arvalid = 1'b0;
      chk("rvalid_one_cycle_after_ar", 32'(rvalid), 32'd1);
      for (int g = 0; g < 100 && !done; g++) begin
         if (rvalid) begin
            if (rd_n == stall_beat && !stalled) begin
               rready = 1'b0; sd = rdata; sl = rlast; sr = rresp; stalled = 1;
               repeat (3) begin
                  @(negedge clk);
                  chk("stall_rvalid", 32'(rvalid), 32'd1);
                  chk("stall_rdata", rdata, sd);
                  chk("stall_rlast", 32'(rlast), 32'(sl));
                  chk("stall_rresp", 32'(rresp), 32'(sr));
               end
               rready = 1'b1;
            end
            if (rd_n < 16) begin rd_d[rd_n] = rdata; rd_r[rd_n] = rresp; rd_l[rd_n] = rlast; end
            chk("rstrb_all_ones", 32'(rstrb), 32'hF);
            rd_id = rid; rd_n++; done = rlast;
         end
         @(posedge clk); @(negedge clk);
      end
      if (!done) tmo("read_burst_end");
      rready = 1'b0;
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_d;
      logic [1:0]  exp_r;
   } vec_t;

   vec_t vt [12];

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] resp; logic [3:0] b_id;
      awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
      wvalid = 0; wid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
      arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
      rstn = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_awready", 32'(awready), 32'd1);
      chk("rst_arready", 32'(arready), 32'd1);
      chk("rst_wready", 32'(wready), 32'd0);
      chk("rst_bvalid", 32'(bvalid), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_rlast", 32'(rlast), 32'd0);
      chk("rst_bid", 32'(bid), 32'd0);
      chk("rst_rid", 32'(rid), 32'd0);
      chk("rst_bresp", 32'(bresp), 32'd0);
      chk("rst_rresp", 32'(rresp), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      rstn = 1'b0;

      // single-beat INCR vectors: {wr, addr, data, strb, expected rdata, expected resp}
      vt[0]  = '{1'b1, 32'h000, 32'h12345678, 4'hF, 32'h0, 2'b00};
      vt[1]  = '{1'b1, 32'h040, 32'h11223344, 4'hF, 32'h0, 2'b00};
      vt[2]  = '{1'b1, 32'h040, 32'hDEADBEEF, 4'h3, 32'h0, 2'b00};
      vt[3]  = '{1'b0, 32'h040, 32'h0, 4'h0, 32'h1122BEEF, 2'b00};
      vt[4]  = '{1'b1, 32'h080, 32'h01020304, 4'hF, 32'h0, 2'b00};
      vt[5]  = '{1'b1, 32'h080, 32'hAABBCCDD, 4'hA, 32'h0, 2'b00};
      vt[6]  = '{1'b0, 32'h080, 32'h0, 4'h0, 32'hAA02CC04, 2'b00};
      vt[7]  = '{1'b1, 32'h3FC, 32'h55AA55AA, 4'hF, 32'h0, 2'b00};
      vt[8]  = '{1'b0, 32'h3FC, 32'h0, 4'h0, 32'h55AA55AA, 2'b00};
      vt[9]  = '{1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 2'b11};
      vt[10] = '{1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 2'b11};
      vt[11] = '{1'b0, 32'h000, 32'h0, 4'h0, 32'h12345678, 2'b00};

      for (int i = 0; i < 12; i++) begin
         if (vt[i].wr) begin
            wd[0] = vt[i].data; ws[0] = vt[i].strb;
            axi_write(4'(i), vt[i].addr, 4'd0, 3'd2, 2'b01, 1, 0, 4'd0, resp, b_id);
            chk($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vt[i].exp_r));
            chk($sformatf("vec%0d_bid", i), 32'(b_id), 32'(i % 16));
         end else begin
            axi_read(4'(i), vt[i].addr, 4'd0, 3'd2, 2'b01, -1);
            chk($sformatf("vec%0d_rdata", i), rd_d[0], vt[i].exp_d);
            chk($sformatf("vec%0d_rresp", i), 32'(rd_r[0]), 32'(vt[i].exp_r));
            chk($sformatf("vec%0d_rlast", i), 32'(rd_l[0]), 32'd1);
            chk($sformatf("vec%0d_rid", i), 32'(rd_id), 32'(i % 16));
         end
      end

      // same-cycle write and read to one word: the read sees the old data
      @(negedge clk);
      awvalid = 1; awid = 4'd1; awaddr = 32'h80; awlen = 0; awsize = 3'd2; awburst = 2'b01;
      @(posedge clk); @(negedge clk);
      awvalid = 0;
      wvalid = 1; wid = 4'd1; wdata = 32'h99887766; wstrb = 4'hF; wlast = 1;
      arvalid = 1; arid = 4'd2; araddr = 32'h80; arlen = 0; arsize = 3'd2; arburst = 2'b01;
      @(posedge clk); @(negedge clk);
      wvalid = 0; wlast = 0; arvalid = 0;
      chk("rw_same_cycle_rvalid", 32'(rvalid), 32'd1);
      chk("rw_same_cycle_old_data", rdata, 32'hAA02CC04);
      chk("rw_same_cycle_bvalid", 32'(bvalid), 32'd1);
      rready = 1; bready = 1;
      @(posedge clk); @(negedge clk);
      rready = 0; bready = 0;
      axi_read(4'd2, 32'h80, 4'd0, 3'd2, 2'b01, -1);
      chk("rw_same_cycle_new_data", rd_d[0], 32'h99887766);

      // 4-beat INCR burst
      for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
      axi_write(4'd5, 32'h10, 4'd3, 3'd2, 2'b01, 4, 3, 4'd0, resp, b_id);
      chk("incr_bresp", 32'(resp), 32'd0);
      chk("incr_bid", 32'(b_id), 32'd5);
      axi_read(4'd9, 32'h10, 4'd3, 3'd2, 2'b01, -1);
      chk("incr_nbeats", 32'(rd_n), 32'd4);
      chk("incr_rid", 32'(rd_id), 32'd9);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("incr_rdata%0d", i), rd_d[i], 32'hA0 + 32'(i));
         chk($sformatf("incr_rlast%0d", i), 32'(rd_l[i]), 32'(i == 3));
      end

      // stall three cycles on beat 2
      axi_read(4'd3, 32'h10, 4'd3, 3'd2, 2'b01, 1);
      chk("stall_nbeats", 32'(rd_n), 32'd4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("stall_beat%0d", i), rd_d[i], 32'hA0 + 32'(i));

      // WRAP burst at 0x38 over a known 0x30..0x3C background
      for (int i = 0; i < 4; i++) begin wd[i] = 32'hB0 + 32'(i); ws[i] = 4'hF; end
      axi_write(4'd1, 32'h30, 4'd3, 3'd2, 2'b01, 4, 3, 4'd0, resp, b_id);
      for (int i = 0; i < 4; i++) wd[i] = 32'hC0 + 32'(i);
      axi_write(4'd1, 32'h38, 4'd3, 3'd2, 2'b10, 4, 3, 4'd0, resp, b_id);
      axi_read(4'd1, 32'h30, 4'd3, 3'd2, 2'b01, -1);
`ifdef AXI_MEM_SLAVE_WRAP_EN
      chk("wrap_bresp", 32'(resp), 32'd0);
      chk("wrap_0x30", rd_d[0], 32'hC2);
      chk("wrap_0x34", rd_d[1], 32'hC3);
      chk("wrap_0x38", rd_d[2], 32'hC0);
      chk("wrap_0x3C", rd_d[3], 32'hC1);
      axi_read(4'd1, 32'h38, 4'd3, 3'd2, 2'b10, -1);
      for (int i = 0; i < 4; i++)
         chk($sformatf("wrap_read%0d", i), rd_d[i], 32'hC0 + 32'(i));
`else
      chk("wrap_bresp", 32'(resp), 32'd2);
      for (int i = 0; i < 4; i++)
         chk($sformatf("wrap_unchanged%0d", i), rd_d[i], 32'hB0 + 32'(i));
      axi_read(4'd1, 32'h38, 4'd3, 3'd2, 2'b10, -1);
      chk("wrap_rresp", 32'(rd_r[0]), 32'd2);
`endif

      // error cases
      wd[0] = 32'hEEEEEEEE; wd[1] = 32'hEEEEEEEE; ws[0] = 4'hF; ws[1] = 4'hF;
      axi_write(4'd2, 32'h200, 4'd3, 3'd2, 2'b01, 2, 1, 4'd0, resp, b_id);
      chk("early_wlast_bresp", 32'(resp), 32'd2);
      axi_write(4'd4, 32'h000, 4'd0, 3'd2, 2'b01, 1, 0, 4'd1, resp, b_id);
      chk("wid_mismatch_bresp", 32'(resp), 32'd2);
      axi_write(4'd4, 32'h040, 4'd0, 3'd1, 2'b01, 1, 0, 4'd0, resp, b_id);
      chk("narrow_size_bresp", 32'(resp), 32'd2);
      axi_write(4'd4, 32'h040, 4'd0, 3'd2, 2'b11, 1, 0, 4'd0, resp, b_id);
      chk("reserved_burst_bresp", 32'(resp), 32'd2);
      axi_read(4'd4, 32'h000, 4'd0, 3'd2, 2'b01, -1);
      chk("wid_mismatch_no_write", rd_d[0], 32'h12345678);
      axi_read(4'd4, 32'h040, 4'd0, 3'd2, 2'b01, -1);
      chk("size_burst_no_write", rd_d[0], 32'h1122BEEF);
      axi_read(4'd4, 32'h040, 4'd0, 3'd2, 2'b11, -1);
      chk("reserved_burst_rresp", 32'(rd_r[0]), 32'd2);
      wd[0] = 32'h77777777; wd[1] = 32'h88888888;
      axi_write(4'd6, 32'h3FC, 4'd1, 3'd2, 2'b01, 2, 1, 4'd0, resp, b_id);
      chk("cross_limit_bresp_decerr", 32'(resp), 32'd3);
      axi_read(4'd6, 32'h3FC, 4'd1, 3'd2, 2'b01, -1);
      chk("cross_limit_rresp0", 32'(rd_r[0]), 32'd0);
      chk("cross_limit_rdata0", rd_d[0], 32'h77777777);
      chk("cross_limit_rresp1", 32'(rd_r[1]), 32'd3);
      chk("cross_limit_rdata1", rd_d[1], 32'd0);

      // reset in the middle of a write burst
      @(negedge clk);
      awvalid = 1; awid = 4'd3; awaddr = 32'h100; awlen = 4'd3; awsize = 3'd2; awburst = 2'b01;
      @(posedge clk); @(negedge clk);
      awvalid = 0;
      chk("midburst_wready", 32'(wready), 32'd1);
      wvalid = 1; wid = 4'd3; wdata = 32'h01010101; wstrb = 4'hF; wlast = 0;
      @(posedge clk); @(negedge clk);
      wvalid = 0; rstn = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("midburst_rst_awready", 32'(awready), 32'd1);
      chk("midburst_rst_wready", 32'(wready), 32'd0);
      chk("midburst_rst_bvalid", 32'(bvalid), 32'd0);
      rstn = 1'b0;
      axi_read(4'd7, 32'h040, 4'd0, 3'd2, 2'b01, -1);
      chk("after_rst_mem_0x40", rd_d[0], 32'h1122BEEF);
      axi_read(4'd7, 32'h000, 4'd0, 3'd2, 2'b01, -1);
      chk("after_rst_mem_0x00", rd_d[0], 32'h12345678);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 Parameter: DATA_W, default 32, data bus width in bits; legal values 32 and 64.
REQ-002 Parameter: ID_W, default 4, width of all ID fields.
REQ-003 Parameter: MEM_DEPTH, default 256, memory depth in DATA_W-bit words; power of two.
REQ-004 Ports: clk in 1, the single clock; rstn in 1, synchronous active-high reset (high = reset, sampled on rising clk).
REQ-005 Write address ports: awvalid in 1; awready out 1; awid in ID_W; awaddr in 32; awlen in 4, beats-1; awsize in 3; awburst in 2.
REQ-006 Write data ports: wvalid in 1; wready out 1; wid in ID_W; wdata in DATA_W; wstrb in DATA_W/8; wlast in 1.
REQ-007 Write response ports: bvalid out 1; bready in 1; bid out ID_W; bresp out 2.
REQ-008 Read address ports: arvalid in 1; arready out 1; arid in ID_W; araddr in 32; arlen in 4; arsize in 3; arburst in 2.
REQ-009 Read data ports: rvalid out 1; rready in 1; rid out ID_W; rdata out DATA_W; rstrb out DATA_W/8; rresp out 2; rlast out 1.

Function
REQ-010 Write and read paths shall be independent FSMs; each path accepts one outstanding burst.
REQ-011 Write FSM states: W_IDLE (awready=1) -> W_DATA on awvalid&awready, capturing awid/awaddr/awlen/awsize/awburst.
REQ-012 In W_DATA, wready=1; each wvalid&wready beat writes mem[word index] byte-wise under wstrb, then advances the address.
REQ-013 W_DATA -> W_RESP on the beat with wlast=1; in W_RESP, bvalid=1 and bid=captured awid; W_RESP -> W_IDLE on bready.
REQ-014 Read FSM states: R_IDLE (arready=1) -> R_DATA on arvalid&arready; first rvalid asserts exactly 1 cycle after the AR handshake.
REQ-015 In R_DATA, rdata/rid/rresp/rlast shall be held stable while rvalid&!rready; the next beat is presented the cycle after rvalid&rready.
REQ-016 rlast=1 on beat arlen+1; R_DATA -> R_IDLE on that beat's handshake; rstrb shall be all ones on every beat.
REQ-017 Word index = (addr >> log2(DATA_W/8)) mod MEM_DEPTH; addr >= MEM_DEPTH*DATA_W/8 is out of range.
REQ-018 Address update per beat: FIXED(00) unchanged; INCR(01) +2^size; WRAP(10) +2^size, wrapping within an aligned (len+1)*2^size window.
REQ-019 Burst type 11 is reserved: no memory writes; response SLVERR (2'b10).
REQ-020 Only full-width size (2^size == DATA_W/8) is supported; other sizes: beats consumed, no writes, SLVERR.
REQ-021 An out-of-range beat: write suppressed / rdata=0; bresp or that rresp shall be DECERR (2'b11).
REQ-022 Write beats shall be suppressed, with bresp SLVERR, when wid != captured awid or wlast arrives on a beat other than awlen+1.
REQ-023 bresp priority: DECERR > SLVERR > OKAY (2'b00), accumulated over the burst.
REQ-024 A same-cycle read and write to one word shall return the pre-write data.

Reset
REQ-025 On rstn=1: both FSMs to IDLE; awready=arready=1; wready=bvalid=rvalid=rlast=0; bid=rid=0; bresp=rresp=0; rdata=0.
REQ-026 Reset mid-burst shall abandon the burst with no response; memory contents are not cleared.

Configuration
REQ-027 Macro AXI_MEM_SLAVE_WRAP_EN defined: WRAP bursts behave per REQ-018; WRAP with len not in {1,3,7,15} gives SLVERR, no writes.
REQ-028 Macro undefined: every WRAP burst is handled as reserved per REQ-019.

Verification
REQ-029 INCR write: awaddr=0x10, awlen=3, awsize=2, wdata 0xA0..0xA3, wstrb=0xF -> bresp=OKAY, bid=awid; INCR read at 0x10 returns A0..A3, rlast on beat 4.
REQ-030 wstrb=0x3 writing 0xDEADBEEF over 0x11223344 at 0x40 -> readback 0x1122BEEF.
REQ-031 WRAP, macro defined: addr=0x38, len=3, size=2 -> writes 0x38,0x3C,0x30,0x34; macro undefined -> SLVERR, memory unchanged.
REQ-032 Read with rready low for 3 cycles on beat 2 -> rdata/rlast stable across the stall, no beat lost or duplicated.
REQ-033 Write to 0x400 with MEM_DEPTH=256 -> DECERR, no write; wlast on beat 2 of a len=3 burst -> SLVERR.
REQ-034 rstn asserted mid W_DATA -> next cycle awready=1, wready=0, bvalid=0; prior memory data intact on readback.
